amba_ahb_resp_mux: RTL and testbench

AMBA_AHB_RESP_MUX -- requirements
Module: amba_ahb_resp_mux

---
 rtl/amba_ahb_resp_mux.sv | 186 ++++++++++++++++++
 tb/tb_amba_ahb_resp_mux.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/amba_ahb_resp_mux.sv
// ---------------------------------------------------------------------------
// amba_ahb_resp_mux
//
// AHB slave-to-master response multiplexer with a built-in default slave.
// The address phase (slave index plus "active" / "unmatched" flags) is
// registered whenever HREADY is high. During the following data phase the
// selected slave's read data, ready and response are routed straight to the
// master with no added latency. Active transfers that hit no slave are
// completed by the default slave and counted in NOMATCH_CNT.
//
// Optional feature (compile-time macro):
//   AHB_DEF_SLAVE_ERROR_EN  - when defined, unmatched active transfers get the
//                             standard two-cycle AHB ERROR response
//                             (IDLE -> ERR1 -> ERR2). When undefined they
//                             complete as zero-wait OKAY with HRDATA = 0.
//
// Parameters:
//   N_SLAVE  number of slaves behind the decoder
//   W_SLAVE  width of the slave index
//   W_DATA   read data width
//
// Ports:
//   HCLK          clock, all state updates on the rising edge
//   HRESET        synchronous active-high reset
//   HSEL          one-hot address-phase select, all-zero = no match
//   HSLAVE        address-phase slave index
//   HTRANS        address-phase transfer type (IDLE/BUSY/NONSEQ/SEQ)
//   HRDATA_S      packed slave read data, slave i at [i*W_DATA +: W_DATA]
//   HREADYOUT_S   per-slave ready
//   HRESP_S       packed slave responses, slave i at [i*2 +: 2]
//   HRDATA        read data to the master
//   HREADY        bus ready to master and all slaves
//   HRESP         response to the master (OKAY=00, ERROR=01)
//   NOMATCH_CNT   saturating count of unmatched active transfers
// ---------------------------------------------------------------------------
module amba_ahb_resp_mux #(
    parameter int N_SLAVE = 2,
    parameter int W_SLAVE = 1,
    parameter int W_DATA  = 32
) (
    input  logic                      HCLK,
    input  logic                      HRESET,
    input  logic [N_SLAVE-1:0]        HSEL,
    input  logic [W_SLAVE-1:0]        HSLAVE,
    input  logic [1:0]                HTRANS,
    input  logic [N_SLAVE*W_DATA-1:0] HRDATA_S,
    input  logic [N_SLAVE-1:0]        HREADYOUT_S,
    input  logic [N_SLAVE*2-1:0]      HRESP_S,
    output logic [W_DATA-1:0]         HRDATA,
    output logic                      HREADY,
    output logic [1:0]                HRESP,
    output logic [7:0]                NOMATCH_CNT
);

    localparam logic [1:0] RESP_OKAY  = 2'b00;
    localparam logic [1:0] RESP_ERROR = 2'b01;

    // Only HTRANS[1] distinguishes an active transfer (NONSEQ/SEQ) from
    // IDLE/BUSY; the low bit carries no meaning for response routing.
    logic unused_htrans_lsb;
    assign unused_htrans_lsb = HTRANS[0];

    // ------------------------------------------------------------------
    // Address phase decode
    // ------------------------------------------------------------------
    logic slave_valid;
    logic addr_hit;
    logic addr_act;
    logic addr_def;

    // An index outside the populated slave range is treated as a miss even
    // when the decoder raised a select, so the default slave answers it.
    always_comb begin
        slave_valid = 1'b0;
        for (int i = 0; i < N_SLAVE; i++) begin
            if (HSLAVE == W_SLAVE'(i)) begin
                slave_valid = 1'b1;
            end
        end
    end

    assign addr_hit = (|HSEL) & slave_valid;
    assign addr_act = HTRANS[1] & addr_hit;
    assign addr_def = HTRANS[1] & ~addr_hit;

    // ------------------------------------------------------------------
    // Address phase -> data phase register
    // ------------------------------------------------------------------
    logic [W_SLAVE-1:0] dp_slave;
    logic               dp_act;
    logic               dp_def;

    // HREADY low holds the data phase, so slave wait states stretch it and a
    // new address phase waits on the bus until the current one completes.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            dp_slave <= '0;
            dp_act   <= 1'b0;
            dp_def   <= 1'b0;
        end else if (HREADY) begin
            dp_slave <= HSLAVE;
            dp_act   <= addr_act;
            dp_def   <= addr_def;
        end
    end

    // ------------------------------------------------------------------
    // Unmatched transfer counter (saturating)
    // ------------------------------------------------------------------
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            NOMATCH_CNT <= 8'd0;
        end else if (HREADY && addr_def && (NOMATCH_CNT != 8'hFF)) begin
            NOMATCH_CNT <= NOMATCH_CNT + 8'd1;
        end
    end

`ifdef AHB_DEF_SLAVE_ERROR_EN
    // ------------------------------------------------------------------
    // Default slave ERROR sequencer
    // ------------------------------------------------------------------
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ERR1 = 2'd1,
        ERR2 = 2'd2
    } def_state_t;

    def_state_t def_state;

    // ERR1 always holds the bus for one cycle. ERR2 drives HREADY high, so a
    // new unmatched transfer accepted there re-enters ERR1 directly.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            def_state <= IDLE;
        end else begin
            case (def_state)
                ERR1:    def_state <= ERR2;
                default: def_state <= (HREADY && addr_def) ? ERR1 : IDLE;
            endcase
        end
    end
`endif

    // ------------------------------------------------------------------
    // Data phase response routing
    // ------------------------------------------------------------------
    logic [W_DATA-1:0] slv_rdata;
    logic              slv_ready;
    logic [1:0]        slv_resp;

    always_comb begin
        slv_rdata = '0;
        slv_ready = 1'b1;
        slv_resp  = RESP_OKAY;
        for (int i = 0; i < N_SLAVE; i++) begin
            if (dp_slave == W_SLAVE'(i)) begin
                slv_rdata = HRDATA_S[i*W_DATA +: W_DATA];
                slv_ready = HREADYOUT_S[i];
                slv_resp  = HRESP_S[i*2 +: 2];
            end
        end
    end

    // With no transfer in its data phase the bus reads as a zero-wait OKAY.
    always_comb begin
        HRDATA = '0;
        HREADY = 1'b1;
        HRESP  = RESP_OKAY;
        if (dp_act) begin
            HRDATA = slv_rdata;
            HREADY = slv_ready;
            HRESP  = slv_resp;
        end else if (dp_def) begin
`ifdef AHB_DEF_SLAVE_ERROR_EN
            // dp_def stays set through both ERR cycles: the first one holds
            // the bus, the second one releases it with ERROR still driven.
            HREADY = (def_state != ERR1);
            HRESP  = RESP_ERROR;
`else
            // Unmatched transfers complete with the zero-wait OKAY defaults.
            HREADY = 1'b1;
`endif
        end
    end

endmodule

// File: tb/tb_amba_ahb_resp_mux.sv
`timescale 1ns/1ps
module tb_amba_ahb_resp_mux;

    localparam int N  = 3;
    localparam int WS = 2;
    localparam int WD = 32;

`ifdef AHB_DEF_SLAVE_ERROR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    localparam logic [1:0] T_IDLE = 2'b00;
    localparam logic [1:0] T_BUSY = 2'b01;
    localparam logic [1:0] T_NSEQ = 2'b10;
    localparam logic [1:0] T_SEQ  = 2'b11;

    logic            HCLK = 1'b0;
    logic            HRESET;
    logic [N-1:0]    HSEL;
    logic [WS-1:0]   HSLAVE;
    logic [1:0]      HTRANS;
    logic [N*WD-1:0] HRDATA_S;
    logic [N-1:0]    HREADYOUT_S;
    logic [2*N-1:0]  HRESP_S;
    logic [WD-1:0]   HRDATA;
    logic            HREADY;
    logic [1:0]      HRESP;
    logic [7:0]      NOMATCH_CNT;

    always #5 HCLK = ~HCLK;

    amba_ahb_resp_mux #(.N_SLAVE(N), .W_SLAVE(WS), .W_DATA(WD)) dut (
        .HCLK(HCLK), .HRESET(HRESET), .HSEL(HSEL), .HSLAVE(HSLAVE),
        .HTRANS(HTRANS), .HRDATA_S(HRDATA_S), .HREADYOUT_S(HREADYOUT_S),
        .HRESP_S(HRESP_S), .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP),
        .NOMATCH_CNT(NOMATCH_CNT)
    );

    int vectors     = 0;
    int miscompares = 0;

    // Transaction-level reference: what kind of transfer is in its data
    // phase, how many default-slave ERROR cycles remain, and the miss count.
    localparam int K_NONE = 0, K_SLAVE = 1, K_DEF = 2;
    int m_kind, m_slave, m_err_left, m_cnt;

    function automatic void model_clear();
        m_kind = K_NONE; m_slave = 0; m_err_left = 0; m_cnt = 0;
    endfunction

    function automatic void model_outputs(output logic [31:0] d, output logic r, output logic [1:0] p);
        d = 32'h0; r = 1'b1; p = 2'b00;
        if (m_err_left == 2) begin
            r = 1'b0; p = 2'b01;
        end else if (m_err_left == 1) begin
            p = 2'b01;
        end else if (m_kind == K_SLAVE) begin
            d = HRDATA_S[m_slave*WD +: WD];
            r = HREADYOUT_S[m_slave];
            p = HRESP_S[m_slave*2 +: 2];
        end
    endfunction

    function automatic void model_step(input logic bus_ready);
        bit hit;
        if (HRESET) begin
            model_clear();
        end else if (bus_ready) begin
            hit = (HSEL != '0) && (int'(HSLAVE) < N);
            if (!HTRANS[1])  m_kind = K_NONE;
            else if (hit)    m_kind = K_SLAVE;
            else             m_kind = K_DEF;
            m_slave    = int'(HSLAVE);
            m_err_left = (m_kind == K_DEF && ERR_EN) ? 2 : 0;
            if (m_kind == K_DEF && m_cnt < 255) m_cnt++;
        end else if (m_err_left == 2) begin
            m_err_left = 1;
        end
    endfunction

    // One bus cycle: compare at the falling edge, advance the model on the
    // rising edge, then leave 1ns for the caller to drive the next inputs.
    task automatic do_cycle(input string name, input bit use_model,
                            input logic [31:0] e_data, input logic e_rdy,
                            input logic [1:0] e_resp, input logic [7:0] e_cnt);
        logic [31:0] md; logic mr; logic [1:0] mp;
        @(negedge HCLK);
        model_outputs(md, mr, mp);
        if (use_model) begin
            e_data = md; e_rdy = mr; e_resp = mp; e_cnt = 8'(m_cnt);
        end
        vectors++;
        if ({HRDATA, HREADY, HRESP, NOMATCH_CNT} !== {e_data, e_rdy, e_resp, e_cnt}) begin
            miscompares++;
            $display("FAIL %s: got rdata=%h ready=%b resp=%b cnt=%0d, want rdata=%h ready=%b resp=%b cnt=%0d",
                     name, HRDATA, HREADY, HRESP, NOMATCH_CNT, e_data, e_rdy, e_resp, e_cnt);
        end
        @(posedge HCLK);
        model_step(mr);
        #1;
    endtask

    task automatic check_cnt(input string name, input logic [7:0] want);
        @(negedge HCLK);
        vectors++;
        if (NOMATCH_CNT !== want) begin
            miscompares++;
            $display("FAIL %s: got cnt=%0d, want cnt=%0d", name, NOMATCH_CNT, want);
        end
    endtask

    typedef struct {
        logic [1:0]      trans;
        logic [N-1:0]    sel;
        logic [WS-1:0]   slv;
        logic [N-1:0]    rdy;
        logic [2*N-1:0]  resp;
        logic [N*WD-1:0] data;
        logic [31:0]     e_data;
        logic            e_rdy;
        logic [1:0]      e_resp;
        logic [7:0]      e_cnt;
    } vec_t;

    function automatic vec_t mk(input logic [1:0] trans, input logic [N-1:0] sel,
                                input logic [WS-1:0] slv, input logic [N-1:0] rdy,
                                input logic [2*N-1:0] resp, input logic [N*WD-1:0] data,
                                input logic [31:0] e_data, input logic e_rdy,
                                input logic [1:0] e_resp, input logic [7:0] e_cnt);
        vec_t v;
        v.trans = trans; v.sel = sel; v.slv = slv; v.rdy = rdy; v.resp = resp;
        v.data = data; v.e_data = e_data; v.e_rdy = e_rdy; v.e_resp = e_resp; v.e_cnt = e_cnt;
        return v;
    endfunction

    task automatic run_vec(input string name, input vec_t v);
        HRESET = 1'b0;
        HTRANS = v.trans; HSEL = v.sel; HSLAVE = v.slv;
        HREADYOUT_S = v.rdy; HRESP_S = v.resp; HRDATA_S = v.data;
        do_cycle(name, 1'b0, v.e_data, v.e_rdy, v.e_resp, v.e_cnt);
    endtask

    task automatic drive_idle();
        HTRANS = T_IDLE; HSEL = '0; HSLAVE = '0;
        HREADYOUT_S = '1; HRESP_S = '0; HRDATA_S = '0;
    endtask

    task automatic reset_dut();
        HRESET = 1'b1;
        drive_idle();
        @(posedge HCLK);
        #1;
        model_clear();
        HRESET = 1'b0;
    endtask

    localparam logic [N*WD-1:0] D_A = {32'h22222222, 32'h11111111, 32'hCAFE0001};
    localparam logic [N*WD-1:0] D_B = {32'h22222222, 32'hBEEF0002, 32'hCAFE0001};
    localparam logic [N*WD-1:0] D_C = {32'h22222222, 32'hBEEF0003, 32'hCAFE0001};
    localparam logic [N*WD-1:0] D_D = {32'h22222222, 32'hBEEF0004, 32'hCAFE0001};
    localparam logic [N*WD-1:0] D_E = {32'h22222222, 32'hBEEF0004, 32'hCAFE0005};
    localparam logic [N*WD-1:0] D_F = {32'hD00D0002, 32'hBEEF0004, 32'hCAFE0005};
    localparam logic [N*WD-1:0] D_X = {3{32'hA5A5A5A5}};

    vec_t tbl[16];
    vec_t seq[$];

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_dut();
        do_cycle("reset_state", 1'b0, 32'h0, 1'b1, 2'b00, 8'd0);

        // Matched transfers, slave wait states, IDLE/BUSY handling.
        tbl[0]  = mk(T_NSEQ, 3'b001, 2'd0, 3'b111, 6'b0,      D_A, 32'h0,        1'b1, 2'b00, 8'd0);
        tbl[1]  = mk(T_IDLE, 3'b000, 2'd0, 3'b111, 6'b0,      D_A, 32'hCAFE0001, 1'b1, 2'b00, 8'd0);
        tbl[2]  = mk(T_NSEQ, 3'b010, 2'd1, 3'b111, 6'b0,      D_B, 32'h0,        1'b1, 2'b00, 8'd0);
        tbl[3]  = mk(T_NSEQ, 3'b100, 2'd2, 3'b101, 6'b0,      D_B, 32'hBEEF0002, 1'b0, 2'b00, 8'd0);
        tbl[4]  = mk(T_NSEQ, 3'b100, 2'd2, 3'b101, 6'b0,      D_C, 32'hBEEF0003, 1'b0, 2'b00, 8'd0);
        tbl[5]  = mk(T_NSEQ, 3'b100, 2'd2, 3'b101, 6'b0,      D_C, 32'hBEEF0003, 1'b0, 2'b00, 8'd0);
        tbl[6]  = mk(T_NSEQ, 3'b001, 2'd0, 3'b111, 6'b0,      D_D, 32'hBEEF0004, 1'b1, 2'b00, 8'd0);
        tbl[7]  = mk(T_IDLE, 3'b000, 2'd0, 3'b111, 6'b000001, D_E, 32'hCAFE0005, 1'b1, 2'b01, 8'd0);
        tbl[8]  = mk(T_BUSY, 3'b000, 2'd0, 3'b111, 6'b0,      D_E, 32'h0,        1'b1, 2'b00, 8'd0);
        tbl[9]  = mk(T_IDLE, 3'b000, 2'd0, 3'b111, 6'b0,      D_E, 32'h0,        1'b1, 2'b00, 8'd0);
        tbl[10] = mk(T_SEQ,  3'b100, 2'd2, 3'b111, 6'b0,      D_F, 32'h0,        1'b1, 2'b00, 8'd0);
        tbl[11] = mk(T_IDLE, 3'b000, 2'd0, 3'b111, 6'b010000, D_F, 32'hD00D0002, 1'b1, 2'b01, 8'd0);
        tbl[12] = mk(T_IDLE, 3'b001, 2'd0, 3'b111, 6'b0,      D_F, 32'h0,        1'b1, 2'b00, 8'd0);
        tbl[13] = mk(T_IDLE, 3'b000, 2'd0, 3'b000, 6'b0,      D_F, 32'h0,        1'b1, 2'b00, 8'd0);
        tbl[14] = mk(T_BUSY, 3'b010, 2'd1, 3'b111, 6'b0,      D_F, 32'h0,        1'b1, 2'b00, 8'd0);
        tbl[15] = mk(T_IDLE, 3'b000, 2'd0, 3'b000, 6'b0,      D_F, 32'h0,        1'b1, 2'b00, 8'd0);
        for (int i = 0; i < 16; i++) run_vec($sformatf("tbl%0d", i), tbl[i]);

        // Single unmatched transfer, then an out-of-range index with a select.
        reset_dut();
        seq.delete();
        seq.push_back(mk(T_NSEQ, 3'b000, 2'd0, 3'b000, 6'b010101, D_X, 32'h0, 1'b1, 2'b00, 8'd0));
`ifdef AHB_DEF_SLAVE_ERROR_EN
        seq.push_back(mk(T_IDLE, 3'b000, 2'd0, 3'b000, 6'b010101, D_X, 32'h0, 1'b0, 2'b01, 8'd1));
        seq.push_back(mk(T_IDLE, 3'b000, 2'd0, 3'b000, 6'b010101, D_X, 32'h0, 1'b1, 2'b01, 8'd1));
        seq.push_back(mk(T_NSEQ, 3'b100, 2'd3, 3'b000, 6'b010101, D_X, 32'h0, 1'b1, 2'b00, 8'd1));
        seq.push_back(mk(T_IDLE, 3'b000, 2'd0, 3'b000, 6'b010101, D_X, 32'h0, 1'b0, 2'b01, 8'd2));
        seq.push_back(mk(T_IDLE, 3'b000, 2'd0, 3'b000, 6'b010101, D_X, 32'h0, 1'b1, 2'b01, 8'd2));
        seq.push_back(mk(T_IDLE, 3'b000, 2'd0, 3'b000, 6'b010101, D_X, 32'h0, 1'b1, 2'b00, 8'd2));
`else
        seq.push_back(mk(T_NSEQ, 3'b100, 2'd3, 3'b000, 6'b010101, D_X, 32'h0, 1'b1, 2'b00, 8'd1));
        seq.push_back(mk(T_IDLE, 3'b000, 2'd0, 3'b000, 6'b010101, D_X, 32'h0, 1'b1, 2'b00, 8'd2));
        seq.push_back(mk(T_IDLE, 3'b000, 2'd0, 3'b000, 6'b010101, D_X, 32'h0, 1'b1, 2'b00, 8'd2));
`endif
        foreach (seq[i]) run_vec($sformatf("nomatch%0d", i), seq[i]);

        // Three back-to-back unmatched transfers.
        reset_dut();
        seq.delete();
`ifdef AHB_DEF_SLAVE_ERROR_EN
        seq.push_back(mk(T_NSEQ, 3'b000, 2'd0, 3'b000, 6'b010101, D_X, 32'h0, 1'b1, 2'b00, 8'd0));
        seq.push_back(mk(T_NSEQ, 3'b000, 2'd0, 3'b000, 6'b010101, D_X, 32'h0, 1'b0, 2'b01, 8'd1));
        seq.push_back(mk(T_NSEQ, 3'b000, 2'd0, 3'b000, 6'b010101, D_X, 32'h0, 1'b1, 2'b01, 8'd1));
        seq.push_back(mk(T_NSEQ, 3'b000, 2'd0, 3'b000, 6'b010101, D_X, 32'h0, 1'b0, 2'b01, 8'd2));
        seq.push_back(mk(T_NSEQ, 3'b000, 2'd0, 3'b000, 6'b010101, D_X, 32'h0, 1'b1, 2'b01, 8'd2));
        seq.push_back(mk(T_IDLE, 3'b000, 2'd0, 3'b000, 6'b010101, D_X, 32'h0, 1'b0, 2'b01, 8'd3));
        seq.push_back(mk(T_IDLE, 3'b000, 2'd0, 3'b000, 6'b010101, D_X, 32'h0, 1'b1, 2'b01, 8'd3));
        seq.push_back(mk(T_IDLE, 3'b000, 2'd0, 3'b000, 6'b010101, D_X, 32'h0, 1'b1, 2'b00, 8'd3));
`else
        seq.push_back(mk(T_NSEQ, 3'b000, 2'd0, 3'b000, 6'b010101, D_X, 32'h0, 1'b1, 2'b00, 8'd0));
        seq.push_back(mk(T_NSEQ, 3'b000, 2'd0, 3'b000, 6'b010101, D_X, 32'h0, 1'b1, 2'b00, 8'd1));
        seq.push_back(mk(T_NSEQ, 3'b000, 2'd0, 3'b000, 6'b010101, D_X, 32'h0, 1'b1, 2'b00, 8'd2));
        seq.push_back(mk(T_IDLE, 3'b000, 2'd0, 3'b000, 6'b010101, D_X, 32'h0, 1'b1, 2'b00, 8'd3));
        seq.push_back(mk(T_IDLE, 3'b000, 2'd0, 3'b000, 6'b010101, D_X, 32'h0, 1'b1, 2'b00, 8'd3));
`endif
        foreach (seq[i]) run_vec($sformatf("b2b%0d", i), seq[i]);

        // Counter saturation, then reset in the middle of an error response.
        reset_dut();
        HTRANS = T_NSEQ; HSEL = '0; HSLAVE = '0; HREADYOUT_S = '0;
        for (int i = 0; i < 640; i++) do_cycle("sat_run", 1'b1, 32'h0, 1'b0, 2'b00, 8'd0);
        check_cnt("sat_255", 8'd255);
        for (int k = 0; k < 4 && m_err_left != 2; k++) do_cycle("to_err1", 1'b1, 32'h0, 1'b0, 2'b00, 8'd0);
        HRESET = 1'b1;
        HTRANS = T_IDLE;
        do_cycle("rst_in_err", 1'b0, 32'h0, !ERR_EN, ERR_EN ? 2'b01 : 2'b00, 8'd255);
        HRESET = 1'b0;
        do_cycle("after_rst0", 1'b0, 32'h0, 1'b1, 2'b00, 8'd0);
        do_cycle("after_rst1", 1'b0, 32'h0, 1'b1, 2'b00, 8'd0);

        // Randomized traffic against the reference model.
        reset_dut();
        for (int i = 0; i < 500; i++) begin
            HRESET = ($urandom_range(0, 63) == 0);
            HTRANS = 2'($urandom_range(0, 3));
            HSLAVE = 2'($urandom_range(0, 3));
            HSEL   = ($urandom_range(0, 2) == 0) ? 3'b000 : 3'(1 << $urandom_range(0, 2));
            for (int s = 0; s < N; s++) begin
                HREADYOUT_S[s] = ($urandom_range(0, 3) != 0);
                HRESP_S[s*2 +: 2] = {1'b0, 1'($urandom_range(0, 1))};
                HRDATA_S[s*WD +: WD] = $urandom;
            end
            do_cycle($sformatf("rand%0d", i), 1'b1, 32'h0, 1'b0, 2'b00, 8'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
